// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester ports and SRAM-side bus shared by mem_arbiter and its users
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  cpuReq;
   logic                  cpuWrite;
   logic [ADDR_WIDTH-1:0] cpuAddr;
   logic [DATA_WIDTH-1:0] cpuWData;
   logic                  cpuAck;
   logic [DATA_WIDTH-1:0] cpuRData;

   logic                  dmaReq;
   logic                  dmaWrite;
   logic [ADDR_WIDTH-1:0] dmaAddr;
   logic [DATA_WIDTH-1:0] dmaWData;
   logic                  dmaAck;
   logic [DATA_WIDTH-1:0] dmaRData;

   logic [ADDR_WIDTH-1:0] memAddr;
   logic [DATA_WIDTH-1:0] memDataOut;
   logic                  memDataOE;
   logic [DATA_WIDTH-1:0] memDataIn;
   logic                  memNotCS;
   logic                  memNotOE;
   logic                  memNotWE;
   logic                  busy;

   // The arbiter answers requests and drives the SRAM.
   modport slave (
      input  cpuReq, cpuWrite, cpuAddr, cpuWData,
      input  dmaReq, dmaWrite, dmaAddr, dmaWData,
      input  memDataIn,
      output cpuAck, cpuRData, dmaAck, dmaRData,
      output memAddr, memDataOut, memDataOE, memNotCS, memNotOE, memNotWE, busy
   );

   modport master (
      output cpuReq, cpuWrite, cpuAddr, cpuWData,
      output dmaReq, dmaWrite, dmaAddr, dmaWData,
      output memDataIn,
      input  cpuAck, cpuRData, dmaAck, dmaRData,
      input  memAddr, memDataOut, memDataOE, memNotCS, memNotOE, memNotWE, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/DMA arbiter for a single asynchronous SRAM
// Fixed SETUP / STROBE / HOLD phasing with every output taken straight from a flop.
module mem_arbiter #(
   parameter int STROBE_CYCLES = 2,
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 16
) (
   input logic          clock,
   input logic          notReset,
   mem_arbiter_if.slave bus
);
   localparam logic [3:0] IDLE   = 4'b0001;
   localparam logic [3:0] SETUP  = 4'b0010;
   localparam logic [3:0] STROBE = 4'b0100;
   localparam logic [3:0] HOLD   = 4'b1000;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

   logic [3:0]            state;
   logic [3:0]            nextState;
   logic [3:0]            strobeCount;
   logic                  lastGrant;
   logic                  txOwner;
   logic                  txWrite;

   logic                  grant;
   logic                  grantOwner;
   logic                  grantWrite;
   logic [ADDR_WIDTH-1:0] grantAddr;
   logic [DATA_WIDTH-1:0] grantWData;

   logic                  nxtOwner;
   logic                  nxtWrite;
   logic                  nxtNotCS;
   logic                  nxtNotOE;
   logic                  nxtNotWE;
   logic                  nxtDataOE;
   logic                  nxtBusy;
   logic                  nxtCpuAck;
   logic                  nxtDmaAck;

   logic [ADDR_WIDTH-1:0] memAddrReg;
   logic [DATA_WIDTH-1:0] memDataOutReg;
   logic                  memDataOEReg;
   logic                  memNotCSReg;
   logic                  memNotOEReg;
   logic                  memNotWEReg;
   logic                  busyReg;
   logic                  cpuAckReg;
   logic                  dmaAckReg;
   logic [DATA_WIDTH-1:0] cpuRDataReg;
   logic [DATA_WIDTH-1:0] dmaRDataReg;

   // State register, transaction latch and registered strobes.
   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         state         <= IDLE;
         strobeCount   <= '0;
         lastGrant     <= OWNER_DMA;
         txOwner       <= OWNER_CPU;
         txWrite       <= 1'b0;
         memAddrReg    <= '0;
         memDataOutReg <= '0;
         memDataOEReg  <= 1'b0;
         memNotCSReg   <= 1'b1;
         memNotOEReg   <= 1'b1;
         memNotWEReg   <= 1'b1;
         busyReg       <= 1'b0;
         cpuAckReg     <= 1'b0;
         dmaAckReg     <= 1'b0;
         cpuRDataReg   <= '0;
         dmaRDataReg   <= '0;
      end else begin
         state        <= nextState;
         txOwner      <= nxtOwner;
         txWrite      <= nxtWrite;
         memDataOEReg <= nxtDataOE;
         memNotCSReg  <= nxtNotCS;
         memNotOEReg  <= nxtNotOE;
         memNotWEReg  <= nxtNotWE;
         busyReg      <= nxtBusy;
         cpuAckReg    <= nxtCpuAck;
         dmaAckReg    <= nxtDmaAck;

         if (grant) begin
            lastGrant     <= grantOwner;
            memAddrReg    <= grantAddr;
            memDataOutReg <= grantWData;
         end

         if (state == SETUP) begin
            strobeCount <= STROBE_LOAD;
         end else if (state == STROBE && strobeCount != '0) begin
            strobeCount <= strobeCount - 4'd1;
         end

         // Read data is taken on the edge that closes the final strobe cycle.
         if (state == STROBE && strobeCount == '0 && !txWrite) begin
            if (txOwner == OWNER_DMA) begin
               dmaRDataReg <= bus.memDataIn;
            end else begin
               cpuRDataReg <= bus.memDataIn;
            end
         end
      end
   end

   always_comb begin
      nextState  = state;
      grant      = 1'b0;
      grantOwner = OWNER_CPU;
      case (state)
         IDLE: begin
            if (bus.cpuReq || bus.dmaReq) begin
               grant     = 1'b1;
               nextState = SETUP;
               if (bus.cpuReq && bus.dmaReq) begin
                  grantOwner = ~lastGrant;
               end else begin
                  grantOwner = bus.dmaReq;
               end
            end
         end
         SETUP:   nextState = STROBE;
         STROBE:  if (strobeCount == '0) nextState = HOLD;
         HOLD:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs are computed for the state being entered, so they switch with it.
   always_comb begin
      grantWrite = (grantOwner == OWNER_DMA) ? bus.dmaWrite : bus.cpuWrite;
      grantAddr  = (grantOwner == OWNER_DMA) ? bus.dmaAddr  : bus.cpuAddr;
      grantWData = (grantOwner == OWNER_DMA) ? bus.dmaWData : bus.cpuWData;
      nxtOwner   = grant ? grantOwner : txOwner;
      nxtWrite   = grant ? grantWrite : txWrite;
      nxtBusy    = (nextState != IDLE);
      nxtNotCS   = ~nxtBusy;
      nxtNotOE   = ~((nextState == STROBE) && !nxtWrite);
      nxtNotWE   = ~((nextState == STROBE) && nxtWrite);
      nxtDataOE  = nxtBusy && nxtWrite;
      nxtCpuAck  = (nextState == HOLD) && (nxtOwner == OWNER_CPU);
      nxtDmaAck  = (nextState == HOLD) && (nxtOwner == OWNER_DMA);
   end

   assign bus.memAddr    = memAddrReg;
   assign bus.memDataOut = memDataOutReg;
   assign bus.memDataOE  = memDataOEReg;
   assign bus.memNotCS   = memNotCSReg;
   assign bus.memNotOE   = memNotOEReg;
   assign bus.memNotWE   = memNotWEReg;
   assign bus.busy       = busyReg;
   assign bus.cpuAck     = cpuAckReg;
   assign bus.dmaAck     = dmaAckReg;
   assign bus.cpuRData   = cpuRDataReg;
   assign bus.dmaRData   = dmaRDataReg;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
   localparam int S  = 2;
   localparam int AW = 16;
   localparam int DW = 16;

   logic clock    = 1'b0;
   logic notReset = 1'b0;
   int   checks   = 0;
   int   errors   = 0;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.STROBE_CYCLES(S), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clock    (clock),
      .notReset (notReset),
      .bus      (bus)
   );

   always #5 clock = ~clock;

   logic [15:0] sram     [0:65535];
   logic [15:0] modelMem [0:65535];
   logic [15:0] addrPool [4] = '{16'h0010, 16'h0020, 16'hFF00, 16'h0042};

   assign bus.memDataIn = (!bus.memNotOE && !bus.memNotCS) ? sram[bus.memAddr] : 16'h0000;

   always @(posedge bus.memNotWE) begin
      if (notReset) sram[bus.memAddr] = bus.memDataOut;
   end

   int          edgeNo = 0;
   int          txStart;
   bit          txValid;
   bit          txOwner;
   bit          txWrite;
   logic [15:0] txAddr;
   logic [15:0] txData;
   bit          lastDma;
   int          freeAt;
   logic [15:0] expAddr;
   logic [15:0] expWData;
   logic [15:0] expCpuR;
   logic [15:0] expDmaR;
   bit          ackLog [$];

   task automatic expectEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, actual, expected, edgeNo);
      end
   endtask

   task automatic resetModel();
      txValid  = 1'b0;
      txStart  = 0;
      lastDma  = 1'b1;
      freeAt   = 0;
      expAddr  = '0;
      expWData = '0;
      expCpuR  = '0;
      expDmaR  = '0;
   endtask

   // One transaction occupies S+3 edges; its ack is visible S+1 edges after the grant.
   task automatic modelEdge();
      bit dma;
      edgeNo++;
      if (!notReset) begin
         resetModel();
         return;
      end
      if (txValid && edgeNo - txStart == S + 1) begin
         if (txWrite) modelMem[txAddr] = txData;
         else if (txOwner) expDmaR = modelMem[txAddr];
         else expCpuR = modelMem[txAddr];
      end
      if (edgeNo >= freeAt && (bus.cpuReq || bus.dmaReq)) begin
         dma      = (bus.cpuReq && bus.dmaReq) ? !lastDma : bus.dmaReq;
         lastDma  = dma;
         txValid  = 1'b1;
         txStart  = edgeNo;
         txOwner  = dma;
         txWrite  = dma ? bus.dmaWrite : bus.cpuWrite;
         txAddr   = dma ? bus.dmaAddr  : bus.cpuAddr;
         txData   = dma ? bus.dmaWData : bus.cpuWData;
         expAddr  = txAddr;
         expWData = txData;
         freeAt   = edgeNo + S + 3;
      end
   endtask

   task automatic checkOutputs();
      int p;
      bit act;
      bit strb;
      p    = edgeNo - txStart;
      act  = notReset && txValid && p >= 0 && p <= S + 1;
      strb = act && p >= 1 && p <= S;
      expectEq("busy",       32'(bus.busy),       32'(act));
      expectEq("memNotCS",   32'(bus.memNotCS),   32'(!act));
      expectEq("memNotOE",   32'(bus.memNotOE),   32'(!(strb && !txWrite)));
      expectEq("memNotWE",   32'(bus.memNotWE),   32'(!(strb && txWrite)));
      expectEq("memDataOE",  32'(bus.memDataOE),  32'(act && txWrite));
      expectEq("cpuAck",     32'(bus.cpuAck),     32'(act && p == S + 1 && !txOwner));
      expectEq("dmaAck",     32'(bus.dmaAck),     32'(act && p == S + 1 && txOwner));
      expectEq("memAddr",    32'(bus.memAddr),    32'(expAddr));
      expectEq("memDataOut", 32'(bus.memDataOut), 32'(expWData));
      expectEq("cpuRData",   32'(bus.cpuRData),   32'(expCpuR));
      expectEq("dmaRData",   32'(bus.dmaRData),   32'(expDmaR));
   endtask

   task automatic stepCycle();
      @(posedge clock);
      modelEdge();
      #1;
      checkOutputs();
      if (bus.cpuAck) ackLog.push_back(1'b0);
      if (bus.dmaAck) ackLog.push_back(1'b1);
   endtask

   task automatic driveRandom();
      bus.cpuReq   = ($urandom_range(0, 3) != 0);
      bus.cpuWrite = 1'($urandom_range(0, 1));
      bus.cpuAddr  = addrPool[$urandom_range(0, 3)];
      bus.cpuWData = 16'($urandom);
      bus.dmaReq   = ($urandom_range(0, 2) != 0);
      bus.dmaWrite = 1'($urandom_range(0, 1));
      bus.dmaAddr  = addrPool[$urandom_range(0, 3)];
      bus.dmaWData = 16'($urandom);
   endtask

   initial begin
      bit found;
      for (int i = 0; i < 65536; i++) begin
         sram[i]     = 16'h0000;
         modelMem[i] = 16'h0000;
      end
      sram[16'h0010]     = 16'hBEEF;
      modelMem[16'h0010] = 16'hBEEF;
      resetModel();

      // Both requesters active while reset is held, then released into contention.
      bus.cpuReq = 1'b1; bus.cpuWrite = 1'b0; bus.cpuAddr = 16'h0010; bus.cpuWData = 16'h5555;
      bus.dmaReq = 1'b1; bus.dmaWrite = 1'b1; bus.dmaAddr = 16'hFF00; bus.dmaWData = 16'h1234;
      repeat (3) stepCycle();
      #2 notReset = 1'b1;
      ackLog.delete();
      repeat (22) stepCycle();
      expectEq("contentionAckCount", 32'(ackLog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < ackLog.size()) expectEq("grantOrder", 32'(ackLog[i]), 32'(i % 2));
      end
      expectEq("cpuReadBeef",  32'(bus.cpuRData), 32'h0000BEEF);
      expectEq("dmaRDataKept", 32'(bus.dmaRData), 32'h00000000);
      expectEq("sramFF00",     32'(sram[16'hFF00]), 32'h00001234);

      // Requester inputs change mid-transaction and must be ignored.
      bus.cpuReq = 1'b0; bus.dmaReq = 1'b0;
      for (int i = 0; i < 10 && edgeNo < freeAt; i++) stepCycle();
      bus.cpuReq = 1'b1; bus.cpuWrite = 1'b0; bus.cpuAddr = 16'h0010;
      stepCycle();
      bus.cpuReq = 1'b0;
      stepCycle();
      bus.cpuAddr = 16'h0020; bus.cpuWrite = 1'b1;
      stepCycle();
      expectEq("stableAddr", 32'(bus.memAddr),  32'h00000010);
      expectEq("stableRead", 32'(bus.memNotOE), 32'd0);
      repeat (4) stepCycle();
      expectEq("stableRData", 32'(bus.cpuRData), 32'h0000BEEF);

      repeat (1500) begin
         driveRandom();
         stepCycle();
      end

      // Reset asserted in the middle of a DMA write strobe.
      bus.cpuReq = 1'b0; bus.dmaReq = 1'b1; bus.dmaWrite = 1'b1;
      bus.dmaAddr = 16'h0042; bus.dmaWData = 16'hA5A5;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         stepCycle();
         if (txValid && txOwner && txWrite && edgeNo - txStart == 1) found = 1'b1;
      end
      expectEq("reachStrobe", 32'(found), 32'd1);
      #2 notReset = 1'b0;
      #1;
      expectEq("rstNotWE", 32'(bus.memNotWE), 32'd1);
      expectEq("rstNotCS", 32'(bus.memNotCS), 32'd1);
      expectEq("rstBusy",  32'(bus.busy),     32'd0);
      expectEq("rstAck",   32'(bus.dmaAck),   32'd0);
      sram[16'h0042] = modelMem[16'h0042];
      repeat (2) stepCycle();
      #2 notReset = 1'b1;
      ackLog.delete();
      repeat (S + 3) stepCycle();
      expectEq("postResetAcks", 32'(ackLog.size()), 32'd1);
      if (ackLog.size() > 0) expectEq("postResetOwner", 32'(ackLog[0]), 32'd1);
      expectEq("postResetWrite", 32'(sram[16'h0042]), 32'h0000A5A5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
